// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shifter.
//   - SHOP_* op codes carried on in_op (5..7 are reserved and yield zero).
//   - calc_sw / calc_nstage derive the log-level count and register-stage count.
//   - shift_payload_t is the per-stage payload {data, op, word, shamt, tag}.
//     Its fields are sized for the widest supported configuration
//     (XLEN=64, TAG_W<=16); narrower configurations use the low bits.
package shift_pkg;

  localparam logic [2:0] SHOP_SLL = 3'd0;
  localparam logic [2:0] SHOP_SRL = 3'd1;
  localparam logic [2:0] SHOP_SRA = 3'd2;
  localparam logic [2:0] SHOP_ROL = 3'd3;
  localparam logic [2:0] SHOP_ROR = 3'd4;

  localparam int SHIFT_DATA_MAX  = 64;
  localparam int SHIFT_SHAMT_MAX = 6;
  localparam int SHIFT_TAG_MAX   = 16;

  function automatic int calc_sw(input int xlen);
    return $clog2(xlen);
  endfunction

  function automatic int calc_nstage(input int sw, input int reg_every);
    return (sw + reg_every - 1) / reg_every;
  endfunction

  typedef struct packed {
    logic [SHIFT_DATA_MAX-1:0]  data;
    logic [2:0]                 op;
    logic                       word;
    logic [SHIFT_SHAMT_MAX-1:0] shamt;
    logic [SHIFT_TAG_MAX-1:0]   tag;
  } shift_payload_t;

endpackage

// File: rtl/shift_pipe_stage.sv
// One register stage of the pipelined shifter: REG_EVERY consecutive
// logarithmic shift levels (levels BASE .. BASE+REG_EVERY-1) followed by
// the stage register.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           clears this stage's valid bit on the next edge
//   advance         global stall control; stage loads only when 1
//   prev_valid      valid bit of the predecessor
//   prev_payload    payload of the predecessor
//   stage_valid     registered valid bit of this stage
//   stage_payload   registered payload of this stage
module shift_pipe_stage
  import shift_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int REG_EVERY = 2,
  parameter int SW        = 6,
  parameter int BASE      = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           advance,
  input  logic           prev_valid,
  input  shift_payload_t prev_payload,
  output logic           stage_valid,
  output shift_payload_t stage_payload
);

  // One log level: shift/rotate by amt. Word rotates wrap inside the low
  // 32 bits; the upper half is don't-care because the result is later
  // sign-extended from bit 31.
  function automatic logic [XLEN-1:0] shift_level(
    input logic [XLEN-1:0] d,
    input logic [2:0]      op,
    input logic            word,
    input int              amt
  );
    logic [31:0]     lo;
    logic [XLEN-1:0] r;
    lo = d[31:0];
    r  = '0;
    case (op)
      SHOP_SLL: r = d << amt;
      SHOP_SRL: r = d >> amt;
      SHOP_SRA: r = XLEN'($signed(d) >>> amt);
      SHOP_ROL: r = word ? XLEN'((lo << amt) | (lo >> (32 - amt)))
                         : ((d << amt) | (d >> (XLEN - amt)));
      SHOP_ROR: r = word ? XLEN'((lo >> amt) | (lo << (32 - amt)))
                         : ((d >> amt) | (d << (XLEN - amt)));
      default:  r = '0;
    endcase
    return r;
  endfunction

  logic [XLEN-1:0] lvl [REG_EVERY+1];
  shift_payload_t  next_payload;

  assign lvl[0] = prev_payload.data[XLEN-1:0];

  for (genvar j = 0; j < REG_EVERY; j++) begin : g_level
    localparam int L = BASE + j;
    if (L < SW) begin : g_active
      assign lvl[j+1] = prev_payload.shamt[L]
                      ? shift_level(lvl[j], prev_payload.op, prev_payload.word, 1 << L)
                      : lvl[j];
    end else begin : g_pass
      // Last stage may be only partly populated when REG_EVERY does not divide SW.
      assign lvl[j+1] = lvl[j];
    end
  end

  always_comb begin
    next_payload      = prev_payload;
    next_payload.data = SHIFT_DATA_MAX'(lvl[REG_EVERY]);
  end

  // Payload loads only with a valid operation, so a bubble never disturbs
  // the last computed value seen on out_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid   <= 1'b0;
      stage_payload <= '0;
    end else if (flush) begin
      stage_valid <= 1'b0;
    end else if (advance) begin
      stage_valid <= prev_valid;
      if (prev_valid) begin
        stage_payload <= next_payload;
      end
    end
  end

endmodule

// File: rtl/shift_pipe_unit.sv
// Pipelined SLL/SRL/SRA/ROL/ROR unit with RV64 word variants.
// Ports:
//   clk, rst            clock, synchronous active-high reset (beats flush)
//   flush               kills every in-flight operation; drops same-cycle input
//   in_valid/in_ready   operation handshake
//   in_op, in_word      op code (SHOP_*), word variant (XLEN=64 only)
//   in_data, in_shamt   operand and shift amount (only low bits used)
//   in_tag              opaque tag passed through
//   out_valid/out_ready result handshake
//   out_data, out_tag   result and its tag
//
// Handshake: a transfer happens on an edge where valid and ready are both 1.
// The whole pipe moves in lockstep: advance = !out_valid || out_ready, and
// in_ready = advance && !flush. When advance is 0 every stage holds, so
// out_valid/out_data/out_tag stay stable until the consumer takes them.
module shift_pipe_unit
  import shift_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_data,
  input  logic [XLEN-1:0]  in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SW     = calc_sw(XLEN);
  localparam int NSTAGE = calc_nstage(SW, REG_EVERY);

  logic            advance;
  logic            word_eff;
  logic [XLEN-1:0] src;
  shift_payload_t  prep;
  shift_payload_t  chain_payload [NSTAGE+1];
  logic [NSTAGE:0] chain_valid;
  shift_payload_t  last;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance && !flush;
  assign word_eff  = (XLEN == 64) && in_word;

  // Operand preparation. Word SRL/SRA need a clean 32-bit source in the
  // full-width shifter; SLL and rotates only care about the low 32 bits.
  // Reserved ops are zeroed here so every level keeps them at zero.
  always_comb begin
    src = in_data;
    if (in_op > SHOP_ROR) begin
      src = '0;
    end else if (word_eff && in_op == SHOP_SRL) begin
      src = XLEN'(in_data[31:0]);
    end else if (word_eff && in_op == SHOP_SRA) begin
      src = XLEN'($signed(in_data[31:0]));
    end

    prep       = '0;
    prep.data  = SHIFT_DATA_MAX'(src);
    prep.op    = in_op;
    prep.word  = word_eff;
    prep.shamt = SHIFT_SHAMT_MAX'(in_shamt[SW-1:0]);
    if (word_eff) begin
      prep.shamt[5] = 1'b0;
    end
    prep.tag   = SHIFT_TAG_MAX'(in_tag);
  end

  assign chain_payload[0] = prep;
  assign chain_valid[0]   = in_valid && in_ready;

  for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
    shift_pipe_stage #(
      .XLEN      (XLEN),
      .REG_EVERY (REG_EVERY),
      .SW        (SW),
      .BASE      (s * REG_EVERY)
    ) u_stage (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .advance       (advance),
      .prev_valid    (chain_valid[s]),
      .prev_payload  (chain_payload[s]),
      .stage_valid   (chain_valid[s+1]),
      .stage_payload (chain_payload[s+1])
    );
  end

  assign last      = chain_payload[NSTAGE];
  assign out_valid = chain_valid[NSTAGE];
  assign out_tag   = last.tag[TAG_W-1:0];

  if (XLEN == 64) begin : g_out64
    assign out_data = last.word ? {{32{last.data[31]}}, last.data[31:0]}
                                : last.data[XLEN-1:0];
  end else begin : g_out32
    assign out_data = last.data[XLEN-1:0];
  end

  // Fields that only ride along to the last stage, plus the ignored upper
  // shift-amount bits, terminate here.
  logic unused_bits;
  assign unused_bits = ^{in_shamt, in_word, last.op, last.shamt, last.tag, last.data};

endmodule

// File: tb/tb_shift_pipe_unit.sv
// Directed bench for shift_pipe_unit (XLEN=64, REG_EVERY=2, latency 3).
module tb_shift_pipe_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic        in_word;
  logic [63:0] in_data;
  logic [63:0] in_shamt;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_tag;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  shift_pipe_unit #(.XLEN(64), .REG_EVERY(2), .TAG_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_word   (in_word),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_op(input logic [2:0] op, input logic word, input logic [63:0] data,
                        input logic [63:0] shamt, input logic [4:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_word  = word;
    in_data  = data;
    in_shamt = shamt;
    in_tag   = tag;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_op    = 3'd0;
    in_word  = 1'b0;
    in_data  = '0;
    in_shamt = '0;
    in_tag   = '0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", name, got, exp);
    end
  endtask

  // Issue one op into an empty pipe, then check latency, data and tag.
  task automatic run_op(input string name, input logic [2:0] op, input logic word,
                        input logic [63:0] data, input logic [63:0] shamt,
                        input logic [4:0] tag, input logic [63:0] exp);
    int lat;
    exp_q.push_back(exp);
    out_ready = 1'b1;
    set_op(op, word, data, shamt, tag);
    settle();
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    idle();
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'd3);
    check({name, "_data"}, out_data, exp_q.pop_front());
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    idle();
    repeat (3) tick();
    rst = 1'b0;
    settle();

    // 1. reset state and shamt masking
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    tick();
    run_op("sll_mask65", 3'd0, 1'b0, 64'h1, 64'd65, 5'd1, 64'h2);

    // 2. full-width shifts and rotates
    run_op("sra4", 3'd2, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 5'd2, 64'hF800_0000_0000_0000);
    run_op("srl4", 3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 5'd3, 64'h0800_0000_0000_0000);
    run_op("ror1", 3'd4, 1'b0, 64'h1, 64'd1, 5'd4, 64'h8000_0000_0000_0000);
    run_op("rol4", 3'd3, 1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'd4, 5'd5, 64'h0F0F_0F0F_0F0F_0F0F);
    run_op("sra63", 3'd2, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("sll0", 3'd0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, 5'd7, 64'h1234_5678_9ABC_DEF0);
    run_op("ror68", 3'd4, 1'b0, 64'h1234, 64'd68, 5'd8, 64'h4000_0000_0000_0123);

    // 3. word variants
    run_op("sllw", 3'd0, 1'b1, 64'h4000_0000, 64'd1, 5'd9, 64'hFFFF_FFFF_8000_0000);
    run_op("sllw_hi", 3'd0, 1'b1, 64'hDEAD_BEEF_4000_0000, 64'd1, 5'd10, 64'hFFFF_FFFF_8000_0000);
    run_op("sraw33", 3'd2, 1'b1, 64'h0000_0000_8000_0000, 64'd33, 5'd11, 64'hFFFF_FFFF_C000_0000);
    run_op("srlw33", 3'd1, 1'b1, 64'h0000_0000_8000_0000, 64'd33, 5'd12, 64'h0000_0000_4000_0000);
    run_op("rorw1", 3'd4, 1'b1, 64'h1, 64'd1, 5'd13, 64'hFFFF_FFFF_8000_0000);
    run_op("rolw4", 3'd3, 1'b1, 64'hFFFF_0000_8000_0001, 64'd4, 5'd14, 64'h0000_0000_0000_0018);

    // 4. back-to-back with stalled consumer; SLL by 1 doubles the operand
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      set_op(3'd0, 1'b0, 64'(i), 64'd1, 5'(i));
      exp_q.push_back(64'(2 * i));
      settle();
      check("b2b_in_ready", 64'(in_ready), 64'd1);
      tick();
    end
    set_op(3'd0, 1'b0, 64'd4, 64'd1, 5'd4);
    exp_q.push_back(64'd8);
    settle();
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    tick();
    tick();
    check("hold_in_ready", 64'(in_ready), 64'd0);
    check("hold_tag", 64'(out_tag), 64'd1);
    check("hold_data", out_data, 64'd2);
    out_ready = 1'b1;
    settle();
    check("release_in_ready", 64'(in_ready), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      check("drain_valid", 64'(out_valid), 64'd1);
      check("drain_tag", 64'(out_tag), 64'(i));
      check("drain_data", out_data, exp_q.pop_front());
      tick();
      idle();
    end
    check("drain_empty", 64'(out_valid), 64'd0);

    // 5. flush with two ops in flight and a same-cycle input
    set_op(3'd0, 1'b0, 64'h11, 64'd1, 5'd20);
    tick();
    set_op(3'd0, 1'b0, 64'h22, 64'd1, 5'd21);
    tick();
    set_op(3'd0, 1'b0, 64'h33, 64'd1, 5'd22);
    flush = 1'b1;
    settle();
    check("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    idle();
    for (int i = 0; i < 5; i++) begin
      check("flush_no_out", 64'(out_valid), 64'd0);
      tick();
    end
    run_op("post_flush", 3'd1, 1'b0, 64'hF0, 64'd4, 5'd23, 64'hF);

    // 6. reserved op, then reset with three ops in flight
    run_op("reserved6", 3'd6, 1'b0, 64'hFFFF, 64'd3, 5'd24, 64'h0);
    for (int i = 0; i < 3; i++) begin
      set_op(3'd0, 1'b0, 64'h5, 64'(i), 5'(25 + i));
      tick();
    end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_data", out_data, 64'd0);
    check("rst_mid_tag", 64'(out_tag), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_no_stale", 64'(out_valid), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
